rr_burst_arbiter: RTL and testbench

Round-robin burst arbiter that shares one downstream resource port (e.g. a memory/writeback bus) among N requesters using valid/ready handshakes. It picks a winner with a rotating-priority search, holds the grant for the winner's whole multi-beat transfer until the beat marked last is accepted, then rotates priority to the requester after the winner. It muxes the winner's data onto the shared port.

---
 rtl/rr_burst_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_rr_burst_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter
// ----------------
// Round-robin burst arbiter. N requesters share one downstream port through
// valid/ready handshakes. A rotating-priority search picks the winner. The
// grant is held for the whole burst, until the beat marked last is accepted.
// Priority then rotates to the requester after the winner.
//
// Optional feature macro: ARB_BURST_CAP_EN
//   When defined, a burst is force-terminated on its MAX_BEATS-th beat.
//   out_last_o is raised on that beat and the owner must re-arbitrate.
//   When undefined, no beat counter is built and bursts are unbounded.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid_i  per-requester beat valid            [N]
//   req_last_i   per-requester last-beat marker      [N]
//   req_data_i   requester data, k at [k*W +: W]     [N*W]
//   req_ready_o  per-requester ready, one-hot or 0   [N]
//   out_valid_o  shared-port valid
//   out_last_o   shared-port last marker
//   out_data_o   shared-port data                    [W]
//   out_sel_o    index of current winner             [$clog2(N)]
//   out_ready_i  shared-port ready
//   locked_o     high while a burst holds the grant
module rr_burst_arbiter #(
    parameter int N         = 4,
    parameter int W         = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid_i,
    input  logic [N-1:0]         req_last_i,
    input  logic [N*W-1:0]       req_data_i,
    output logic [N-1:0]         req_ready_o,
    output logic                 out_valid_o,
    output logic                 out_last_o,
    output logic [W-1:0]         out_data_o,
    output logic [$clog2(N)-1:0] out_sel_o,
    input  logic                 out_ready_i,
    output logic                 locked_o
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [N-1:0]  PRIO_RST = N'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Binary index of a one-hot vector.
    function automatic logic [IW-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = idx | (oh[i] ? IW'(i) : {IW{1'b0}});
        end
        return idx;
    endfunction

    // One-hot vector with the given bit set.
    function automatic logic [N-1:0] idx_to_onehot(input logic [IW-1:0] idx);
        return PRIO_RST << idx;
    endfunction

    state_t        state_r, state_nxt_s;
    logic [N-1:0]  prio_r, prio_nxt_s;
    logic [IW-1:0] owner_r, owner_nxt_s;
    logic [IW-1:0] prio_idx_s, winner_s, cand_s;
    logic [N-1:0]  ready_s;
    logic          valid_s, last_s;
    logic [W-1:0]  data_s;
    logic [IW-1:0] sel_s;

`ifdef ARB_BURST_CAP_EN
    localparam int CW = $clog2(MAX_BEATS) + 1;
    localparam logic [CW-1:0] CNT_CAP = CW'(MAX_BEATS - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          cap_hit_s;
`endif

    // Circular search from the priority index. The scan runs from the
    // farthest offset down to offset 0, so the nearest valid requester is
    // assigned last and wins. Index wrap relies on N being a power of two.
    always_comb begin
        prio_idx_s = onehot_to_idx(prio_r);
        winner_s   = prio_idx_s;
        cand_s     = prio_idx_s;
        for (int i = N - 1; i >= 0; i--) begin
            cand_s = prio_idx_s + IW'(i);
            if (req_valid_i[cand_s]) begin
                winner_s = cand_s;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // Next-state logic and the shared-port mux.
    always_comb begin
        state_nxt_s = state_r;
        prio_nxt_s  = prio_r;
        owner_nxt_s = owner_r;
        sel_s       = prio_idx_s;
        valid_s     = 1'b0;
        last_s      = 1'b0;
        data_s      = '0;
        ready_s     = '0;
`ifdef ARB_BURST_CAP_EN
        cnt_nxt_s   = cnt_r;
        cap_hit_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                sel_s   = winner_s;
                valid_s = |req_valid_i;
                if (valid_s) begin
                    data_s            = req_data_i[winner_s*W +: W];
                    last_s            = req_last_i[winner_s];
                    ready_s[winner_s] = out_ready_i;
                end else begin
                    data_s  = '0;
                    last_s  = 1'b0;
                end
                if (valid_s && out_ready_i) begin
                    if (last_s) begin
                        prio_nxt_s = idx_to_onehot(winner_s + IDX_ONE);
                    end else begin
                        state_nxt_s = LOCK;
                        owner_nxt_s = winner_s;
`ifdef ARB_BURST_CAP_EN
                        cnt_nxt_s   = CNT_ONE;
`endif
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCK: begin
                sel_s            = owner_r;
                valid_s          = req_valid_i[owner_r];
                data_s           = req_data_i[owner_r*W +: W];
                ready_s[owner_r] = out_ready_i;
`ifdef ARB_BURST_CAP_EN
                cap_hit_s        = (cnt_r == CNT_CAP);
                last_s           = req_last_i[owner_r] | cap_hit_s;
`else
                last_s           = req_last_i[owner_r];
`endif
                if (valid_s && out_ready_i) begin
                    if (last_s) begin
                        state_nxt_s = IDLE;
                        prio_nxt_s  = idx_to_onehot(owner_r + IDX_ONE);
                    end else begin
`ifdef ARB_BURST_CAP_EN
                        cnt_nxt_s   = cnt_r + CNT_ONE;
`endif
                        state_nxt_s = LOCK;
                    end
                end else begin
                    state_nxt_s = LOCK;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Outputs are forced to their reset values while rst_n is low, so an
    // abandoned burst releases the port within the same cycle.
    always_comb begin
        if (rst_n) begin
            req_ready_o = ready_s;
            out_valid_o = valid_s;
            out_last_o  = last_s;
            out_data_o  = data_s;
            out_sel_o   = sel_s;
            locked_o    = (state_r == LOCK);
        end else begin
            req_ready_o = '0;
            out_valid_o = 1'b0;
            out_last_o  = 1'b0;
            out_data_o  = '0;
            out_sel_o   = '0;
            locked_o    = 1'b0;
        end
    end

    // State, priority pointer and owner registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            prio_r  <= PRIO_RST;
            owner_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            prio_r  <= prio_nxt_s;
            owner_r <= owner_nxt_s;
        end
    end

`ifdef ARB_BURST_CAP_EN
    // Beat counter for the burst cap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`endif

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed testbench for rr_burst_arbiter (N = 4, W = 32).
// The burst-cap scenario is compiled only when ARB_BURST_CAP_EN is defined.
module tb_rr_burst_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic           out_last;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;
    logic           locked;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_burst_arbiter #(.N(N), .W(W), .MAX_BEATS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid_i(req_valid),
        .req_last_i (req_last),
        .req_data_i (req_data),
        .req_ready_o(req_ready),
        .out_valid_o(out_valid),
        .out_last_o (out_last),
        .out_data_o (out_data),
        .out_sel_o  (out_sel),
        .out_ready_i(out_ready),
        .locked_o   (locked)
    );

    function automatic logic [W-1:0] beat_data(input int k, input int b);
        return 32'hA000_0000 | (32'(k) << 8) | 32'(b);
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 4'b0000; req_last = 4'b0000;
        req_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b exp 0", locked); end
        n_tests++; if (out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d exp 0", out_sel); end
        n_tests++; if (out_data !== 32'h0 || out_last !== 1'b0) begin n_fail++; $display("FAIL reset_data got %h/%b exp 0/0", out_data, out_last); end
        next_cycle();
    endtask

    task automatic test_rr_single;
        logic [1:0] exp_sel;
        req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < N; k++) req_data[k*W +: W] = beat_data(k, 0);
        for (int i = 0; i < 8; i++) begin
            exp_sel = 2'(i % 4);
            #3;
            n_tests++; if (out_sel !== exp_sel) begin n_fail++; $display("FAIL rr_sel[%0d] got %0d exp %0d", i, out_sel, exp_sel); end
            n_tests++; if (req_ready !== (4'b0001 << exp_sel)) begin n_fail++; $display("FAIL rr_ready[%0d] got %b exp %b", i, req_ready, 4'b0001 << exp_sel); end
            n_tests++; if (out_data !== beat_data(int'(exp_sel), 0)) begin n_fail++; $display("FAIL rr_data[%0d] got %h", i, out_data); end
            next_cycle();
        end
        req_valid = 4'b0000; req_last = 4'b0000;
    endtask

    task automatic test_burst_lock;
        // Single beat from requester 1 moves priority to requester 2.
        req_valid = 4'b0010; req_last = 4'b0010; out_ready = 1'b1;
        req_data[1*W +: W] = beat_data(1, 0);
        #3;
        n_tests++; if (out_sel !== 2'd1) begin n_fail++; $display("FAIL lock_pre_sel got %0d exp 1", out_sel); end
        next_cycle();
        req_valid = 4'b1101; req_last = 4'b1001;
        req_data[0*W +: W] = beat_data(0, 0);
        req_data[3*W +: W] = beat_data(3, 0);
        for (int b = 0; b < 3; b++) begin
            req_data[2*W +: W] = beat_data(2, b);
            req_last[2] = (b == 2);
            #3;
            n_tests++; if (out_sel !== 2'd2) begin n_fail++; $display("FAIL lock_sel[%0d] got %0d exp 2", b, out_sel); end
            n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL lock_ready[%0d] got %b exp 0100", b, req_ready); end
            n_tests++; if (out_data !== beat_data(2, b)) begin n_fail++; $display("FAIL lock_data[%0d] got %h exp %h", b, out_data, beat_data(2, b)); end
            next_cycle();
        end
        req_valid = 4'b1001;
        #3;
        n_tests++; if (out_sel !== 2'd3 || req_ready !== 4'b1000) begin n_fail++; $display("FAIL lock_next3 got sel %0d ready %b exp 3/1000", out_sel, req_ready); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_released got %b exp 0", locked); end
        next_cycle();
        #3;
        n_tests++; if (out_sel !== 2'd0 || req_ready !== 4'b0001) begin n_fail++; $display("FAIL lock_next0 got sel %0d ready %b exp 0/0001", out_sel, req_ready); end
        next_cycle();
        req_valid = 4'b0000; req_last = 4'b0000;
    endtask

    task automatic test_backpressure;
        logic [8:0] v_tab = 9'b111100111;  // bit c = requester 1 valid in cycle c
        logic [8:0] r_tab = 9'b101000101;  // bit c = out_ready in cycle c
        int b  = 0;
        int hs = 0;
        req_valid = 4'b0100; req_last = 4'b0100;
        req_data[2*W +: W] = beat_data(2, 9);
        for (int c = 0; c < 9; c++) begin
            req_valid[1] = v_tab[c];
            out_ready = r_tab[c];
            req_data[1*W +: W] = beat_data(1, b);
            req_last[1] = (b == 3);
            #3;
            n_tests++; if (out_sel !== 2'd1) begin n_fail++; $display("FAIL bp_sel[%0d] got %0d exp 1", c, out_sel); end
            n_tests++; if (locked !== (c != 0)) begin n_fail++; $display("FAIL bp_locked[%0d] got %b exp %b", c, locked, c != 0); end
            n_tests++; if (req_ready !== (r_tab[c] ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL bp_ready[%0d] got %b", c, req_ready); end
            if (out_valid && out_ready) begin
                n_tests++; if (out_data !== beat_data(1, b)) begin n_fail++; $display("FAIL bp_data[%0d] got %h exp %h", b, out_data, beat_data(1, b)); end
                hs++;
                b++;
            end
            next_cycle();
        end
        n_tests++; if (hs !== 4) begin n_fail++; $display("FAIL bp_handshakes got %0d exp 4", hs); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL bp_exit got %b exp 0", locked); end
        req_valid = 4'b0000; req_last = 4'b0000; out_ready = 1'b1;
    endtask

    task automatic test_reset_mid;
        req_valid = 4'b1000; req_last = 4'b0000; out_ready = 1'b1;
        req_data[3*W +: W] = beat_data(3, 0);
        #3;
        n_tests++; if (out_sel !== 2'd3) begin n_fail++; $display("FAIL rmid_sel got %0d exp 3", out_sel); end
        next_cycle();
        #1;
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rmid_locked got %b exp 1", locked); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rmid_lock_drop got %b exp 0", locked); end
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rmid_ready got %b exp 0000", req_ready); end
        next_cycle();
        rst_n = 1'b1;
        req_valid = 4'b1010; req_last = 4'b1010;
        req_data[1*W +: W] = beat_data(1, 0);
        #3;
        n_tests++; if (out_sel !== 2'd1 || req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmid_after got sel %0d ready %b exp 1/0010", out_sel, req_ready); end
        next_cycle();
        req_valid = 4'b0000; req_last = 4'b0000;
    endtask

`ifdef ARB_BURST_CAP_EN
    task automatic test_burst_cap;
        // Priority sits at requester 2, so requester 0 wins over requester 1.
        req_valid = 4'b0011; req_last = 4'b0000; out_ready = 1'b1;
        req_data[1*W +: W] = beat_data(1, 0);
        for (int b = 1; b <= 4; b++) begin
            req_data[0*W +: W] = beat_data(0, b);
            #3;
            n_tests++; if (out_sel !== 2'd0) begin n_fail++; $display("FAIL cap_sel[%0d] got %0d exp 0", b, out_sel); end
            n_tests++; if (out_last !== (b == 4)) begin n_fail++; $display("FAIL cap_last[%0d] got %b exp %b", b, out_last, b == 4); end
            next_cycle();
        end
        #3;
        n_tests++; if (out_sel !== 2'd1 || locked !== 1'b0) begin n_fail++; $display("FAIL cap_next got sel %0d locked %b exp 1/0", out_sel, locked); end
        next_cycle();
        req_valid = 4'b0000;
    endtask
`endif

    initial begin
        test_reset();
        test_rr_single();
        test_burst_lock();
        test_backpressure();
        test_reset_mid();
`ifdef ARB_BURST_CAP_EN
        test_burst_cap();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
